mac_pipe_acc: RTL and testbench

Parametrised pipelined multiply-accumulate block and the successor to the fixed 8x8 MAC in the same datapath library. It adds configurable operand and accumulator width, signed/unsigned mode, a valid handshake, a synchronous clear, and optional saturation. A term counter pulses done after a programmable number of accumulated products. It targets a single hard MULT/MAC primitive with its input, product and accumulator registers.

---
 rtl/mac_pkg.sv | 49 ++++
 rtl/mac_sat_add.sv | 48 ++++
 rtl/mac_pipe_acc.sv | 157 +++++++++++++++
 tb/tb_mac_pipe_acc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared helpers for the mac_pipe_acc datapath: extension bit,
//                overflow predicate and saturation selection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  // Width of the term counter; bounds the legal ACC_LEN range.
  localparam int unsigned CNT_W = 16;

  // Which value the adder drives onto its sum output.
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_UMAX = 2'd1,
    SAT_SMAX = 2'd2,
    SAT_SMIN = 2'd3
  } sat_sel_e;

  // Fill bit used when widening a product to accumulator width.
  function automatic logic ext_bit(input logic sgn, input logic msb);
    return sgn & msb;
  endfunction

  // Unsigned: carry out of the top bit. Signed: like-signed operands whose
  // result takes the other sign.
  function automatic logic ovf_pred(input logic sgn, input logic carry,
                                    input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    if (sgn)
      return (a_msb == b_msb) && (s_msb != a_msb);
    return carry;
  endfunction

  // On signed overflow both operands share a sign, so a's sign picks the rail.
  function automatic sat_sel_e sat_select(input logic sgn, input logic sat_en,
                                          input logic ovf, input logic a_msb);
    if (!(sat_en && ovf))
      return SAT_NONE;
    if (!sgn)
      return SAT_UMAX;
    return a_msb ? SAT_SMIN : SAT_SMAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sat_add.sv
// ============================================================================
//  Module      : mac_sat_add
//  Description : Combinational OSIZE-bit adder with overflow flag and optional
//                clamp to the signed/unsigned rails.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_sat_add
  import mac_pkg::*;
#(
  parameter int OSIZE    = 17,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [OSIZE-1:0] i_a,
  input  logic [OSIZE-1:0] i_b,
  output logic [OSIZE-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic c_sgn = (SIGNED != 0);
  localparam logic c_sat = (SATURATE != 0);

  logic [OSIZE:0]   w_full;
  logic [OSIZE-1:0] w_raw;
  sat_sel_e         w_sel;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign w_raw  = w_full[OSIZE-1:0];
  assign o_ovf  = ovf_pred(c_sgn, w_full[OSIZE], i_a[OSIZE-1], i_b[OSIZE-1],
                           w_raw[OSIZE-1]);
  assign w_sel  = sat_select(c_sgn, c_sat, o_ovf, i_a[OSIZE-1]);

  // Pick the wrapped sum or the appropriate saturation rail.
  always_comb begin
    o_sum = w_raw;
    case (w_sel)
      SAT_UMAX: o_sum = {OSIZE{1'b1}};
      SAT_SMAX: o_sum = {1'b0, {(OSIZE-1){1'b1}}};
      SAT_SMIN: o_sum = {1'b1, {(OSIZE-1){1'b0}}};
      default:  o_sum = w_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mac_pipe_acc.sv
// ============================================================================
//  Module      : mac_pipe_acc
//  Description : Three-stage pipelined multiply-accumulate (input register,
//                product register, accumulator) with clear, sticky overflow,
//                optional saturation and a term counter that pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_pipe_acc
  import mac_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int OSIZE    = 17,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int ACC_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] x,
  input  logic [DSIZE-1:0] y,
  input  logic             in_valid,
  input  logic             clr,
  output logic [OSIZE-1:0] dataout,
  output logic             done,
  output logic             ovf,
  output logic             busy
);

  localparam int         PW        = 2 * DSIZE;
  localparam logic       c_sgn     = (SIGNED != 0);
  localparam [CNT_W-1:0] c_acc_len = CNT_W'(ACC_LEN);

  // Stage 1: operand capture
  logic [DSIZE-1:0] r_x;
  logic [DSIZE-1:0] r_y;
  logic             r_v1;
  logic             r_f1;

  // Stage 2: product
  logic [PW-1:0]    r_p;
  logic             r_v2;
  logic             r_f2;

  // Stage 3: accumulator and control
  logic [OSIZE-1:0] r_acc;
  logic             r_ovf;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic [PW-1:0]    w_xe;
  logic [PW-1:0]    w_ye;
  logic [PW-1:0]    w_prod;
  logic [OSIZE-1:0] w_ext;
  logic [OSIZE-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_first;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Widening both operands to the product width makes the low PW bits of the
  // multiply correct for either signedness.
  assign w_xe   = {{DSIZE{c_sgn & r_x[DSIZE-1]}}, r_x};
  assign w_ye   = {{DSIZE{c_sgn & r_y[DSIZE-1]}}, r_y};
  assign w_prod = w_xe * w_ye;

  generate
    if (OSIZE > PW) begin : g_ext_wide
      assign w_ext = {{(OSIZE-PW){ext_bit(c_sgn, r_p[PW-1])}}, r_p};
    end else begin : g_ext_equal
      assign w_ext = r_p;
    end
  endgenerate

  mac_sat_add #(
    .OSIZE    (OSIZE),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // A clear or an empty count makes this term the start of a new sum.
  assign w_first   = r_f2 | (r_cnt == '0);
  assign w_cnt_nxt = w_first ? CNT_W'(1) : (r_cnt + CNT_W'(1));

  // Stage 1: register operands on valid; data holds through gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_x  <= x;
        r_y  <= y;
        r_f1 <= clr;
      end else begin
        r_f1 <= 1'b0;
      end
    end
  end

  // Stage 2: register the full-width product and forward valid/first flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p  <= '0;
      r_v2 <= 1'b0;
      r_f2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      r_f2 <= r_f1;
      if (r_v1)
        r_p <= w_prod;
    end
  end

  // Stage 3: load or accumulate, track overflow, count terms, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_v2) begin
        if (w_first) begin
          r_acc <= w_ext;
          r_ovf <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | w_add_ovf;
        end
        if (w_cnt_nxt == c_acc_len) begin
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= w_cnt_nxt;
        end
      end
    end
  end

  assign dataout = r_acc;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign busy    = r_v1 | r_v2 | (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe_acc.sv
// ============================================================================
//  Module      : tb_mac_pipe_acc
//  Description : Directed self-checking bench for mac_pipe_acc. Four
//                instances share stimulus: unsigned/saturating, signed
//                saturating, signed wrapping, and unsigned with ACC_LEN=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_pipe_acc;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] y;
  logic       in_valid;
  logic       clr;

  logic [16:0] uns_dout, ssat_dout, swrap_dout, a1_dout;
  logic        uns_done, ssat_done, swrap_done, a1_done;
  logic        uns_ovf,  ssat_ovf,  swrap_ovf,  a1_ovf;
  logic        uns_busy, ssat_busy, swrap_busy, a1_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mac_pipe_acc #(.DSIZE(8), .OSIZE(17), .SIGNED(0), .SATURATE(1), .ACC_LEN(4)) u_uns (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid), .clr(clr),
    .dataout(uns_dout), .done(uns_done), .ovf(uns_ovf), .busy(uns_busy));

  mac_pipe_acc #(.DSIZE(8), .OSIZE(17), .SIGNED(1), .SATURATE(1), .ACC_LEN(4)) u_ssat (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid), .clr(clr),
    .dataout(ssat_dout), .done(ssat_done), .ovf(ssat_ovf), .busy(ssat_busy));

  mac_pipe_acc #(.DSIZE(8), .OSIZE(17), .SIGNED(1), .SATURATE(0), .ACC_LEN(4)) u_swrap (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid), .clr(clr),
    .dataout(swrap_dout), .done(swrap_done), .ovf(swrap_ovf), .busy(swrap_busy));

  mac_pipe_acc #(.DSIZE(8), .OSIZE(17), .SIGNED(0), .SATURATE(1), .ACC_LEN(1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid), .clr(clr),
    .dataout(a1_dout), .done(a1_done), .ovf(a1_ovf), .busy(a1_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then step just past the rising edge.
  task automatic cyc(input logic [7:0] a, input logic [7:0] b,
                     input logic v, input logic c);
    x = a; y = b; in_valid = v; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    x = 8'd0; y = 8'd0; in_valid = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; x = 8'd0; y = 8'd0; in_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",  uns_dout,  0);
    check("rst_done",  uns_done,  0);
    check("rst_ovf",   uns_ovf,   0);
    check("rst_busy",  uns_busy,  0);
    check("rst_sdout", ssat_dout, 0);
    check("rst_a1",    a1_busy,   0);
    rst_n = 1'b1;

    // Unsigned saturation: 255*255 x4
    cyc(8'd255, 8'd255, 1'b1, 1'b1);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    check("u1_t1", uns_dout, 65025);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    check("u1_t2", uns_dout, 130050);
    check("u1_t2_ovf", uns_ovf, 0);
    idle();
    check("u1_t3", uns_dout, 131071);
    check("u1_t3_ovf", uns_ovf, 1);
    check("u1_t3_done", uns_done, 0);
    idle();
    check("u1_t4", uns_dout, 131071);
    check("u1_t4_ovf", uns_ovf, 1);
    check("u1_t4_done", uns_done, 1);
    idle();
    check("u1_done_low", uns_done, 0);

    // Signed: -128*-128 x4, saturating and wrapping
    reset_dut();
    cyc(8'h80, 8'h80, 1'b1, 1'b1);
    cyc(8'h80, 8'h80, 1'b1, 1'b0);
    cyc(8'h80, 8'h80, 1'b1, 1'b0);
    check("s_t1", ssat_dout, 16384);
    cyc(8'h80, 8'h80, 1'b1, 1'b0);
    check("s_t2", ssat_dout, 32768);
    idle();
    check("s_t3", ssat_dout, 49152);
    check("sw_t3", swrap_dout, 49152);
    check("s_t3_ovf", ssat_ovf, 0);
    idle();
    check("s_t4_sat", ssat_dout, 65535);
    check("s_t4_ovf", ssat_ovf, 1);
    check("s_t4_done", ssat_done, 1);
    check("sw_t4_wrap", swrap_dout, 32'h10000);
    check("sw_t4_ovf", swrap_ovf, 1);
    check("sw_t4_done", swrap_done, 1);

    // Gaps in valid; done only on the 4th term, then a fresh start
    reset_dut();
    cyc(8'd3, 8'd4, 1'b1, 1'b0);
    cyc(8'd5, 8'd6, 1'b1, 1'b0);
    idle();
    check("g_t1", uns_dout, 12);
    idle();
    check("g_t2", uns_dout, 42);
    idle();
    check("g_hold1", uns_dout, 42);
    cyc(8'd7, 8'd8, 1'b1, 1'b0);
    check("g_hold2", uns_dout, 42);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    check("g_hold3", uns_dout, 42);
    check("g_nodone", uns_done, 0);
    idle();
    check("g_t3", uns_dout, 98);
    check("g_t3_done", uns_done, 0);
    idle();
    check("g_t4", uns_dout, 99);
    check("g_t4_done", uns_done, 1);
    idle();
    check("g_done_low", uns_done, 0);
    cyc(8'd2, 8'd2, 1'b1, 1'b0);
    idle();
    idle();
    check("g_restart", uns_dout, 4);
    check("g_restart_done", uns_done, 0);

    // clr mid-accumulation restarts the count at 1
    reset_dut();
    cyc(8'd10, 8'd10, 1'b1, 1'b0);
    cyc(8'd10, 8'd10, 1'b1, 1'b0);
    cyc(8'd1, 8'd2, 1'b1, 1'b1);
    check("c_t1", uns_dout, 100);
    idle();
    check("c_t2", uns_dout, 200);
    idle();
    check("c_clr", uns_dout, 2);
    check("c_clr_done", uns_done, 0);
    check("c_clr_ovf", uns_ovf, 0);
    check("c_busy_cnt", uns_busy, 1);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    check("c_p2", uns_dout, 3);
    idle();
    check("c_p3", uns_dout, 4);
    check("c_p3_done", uns_done, 0);
    idle();
    check("c_p4", uns_dout, 5);
    check("c_p4_done", uns_done, 1);
    check("c_busy_idle", uns_busy, 0);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    cyc(8'd255, 8'd255, 1'b1, 1'b0);
    cyc(8'd1, 8'd2, 1'b1, 1'b1);
    idle();
    check("c_ovf_set", uns_ovf, 1);
    idle();
    check("c_ovf_clr_dout", uns_dout, 2);
    check("c_ovf_clr", uns_ovf, 0);
    check("c_ovf_clr_done", uns_done, 0);

    // Asynchronous reset mid-stream
    reset_dut();
    cyc(8'd10, 8'd10, 1'b1, 1'b0);
    cyc(8'd10, 8'd10, 1'b1, 1'b0);
    idle();
    check("r_pre_dout", uns_dout, 100);
    check("r_pre_busy", uns_busy, 1);
    rst_n = 1'b0;
    #2;
    check("r_dout", uns_dout, 0);
    check("r_busy", uns_busy, 0);
    check("r_ovf",  uns_ovf,  0);
    check("r_done", uns_done, 0);
    #2;
    rst_n = 1'b1;
    cyc(8'd9, 8'd9, 1'b1, 1'b0);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    check("r_first", uns_dout, 81);
    check("r_first_done", uns_done, 0);
    cyc(8'd1, 8'd1, 1'b1, 1'b0);
    check("r_t2", uns_dout, 82);
    idle();
    check("r_t3", uns_dout, 83);
    idle();
    check("r_t4", uns_dout, 84);
    check("r_t4_done", uns_done, 1);

    // ACC_LEN=1: every term completes
    reset_dut();
    cyc(8'd2, 8'd3, 1'b1, 1'b0);
    cyc(8'd4, 8'd5, 1'b1, 1'b0);
    idle();
    check("a1_t1", a1_dout, 6);
    check("a1_t1_done", a1_done, 1);
    idle();
    check("a1_t2", a1_dout, 20);
    check("a1_t2_done", a1_done, 1);
    idle();
    check("a1_idle_done", a1_done, 0);
    check("a1_idle_hold", a1_dout, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
